// File: rtl/drops_engine_pkg.sv
// Shared definitions for the drops game engine: FSM encoding, LFSR taps
// and the grid-size legality check.
package drops_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INPUT = 3'd1,
    ST_STEP  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic bit gs_legal(input int gs);
    return (gs >= 4) && (gs <= 16) && ((gs & (gs - 1)) == 0);
  endfunction

endpackage

// File: rtl/drops_lfsr.sv
// Free-running 16-bit Galois LFSR with enable; a zero seed would lock up,
// so it is replaced by 1.
module drops_lfsr
  import drops_engine_pkg::*;
#(
  parameter int unsigned    W    = 16,
  parameter logic [W-1:0]   SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [W-1:0] TAPS     = W'(LFSR_TAPS);

  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/drops_engine.sv
// Drops game core: one frame = INPUT, STEP, then a GS-row scan of the LED
// matrix. Drops fall from row 0, the paddle lives in row GS-1.
module drops_engine
  import drops_engine_pkg::*;
#(
  parameter int unsigned GS       = 8,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned LIVES    = 3,
  parameter int unsigned SCORE_W  = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               start_i,
  output logic [GS-1:0]      row_o,
  output logic [GS-1:0]      col_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [2:0]         lives_o,
  output logic               game_over_o,
  output logic               frame_o
);

  localparam int unsigned        CW          = $clog2(GS);
  localparam logic [CW-1:0]      PLAYER_INIT = CW'(GS / 2);
  localparam logic [CW-1:0]      LAST_IDX    = CW'(GS - 1);
  localparam logic [7:0]         TICK_LAST   = 8'(TICK_DIV - 1);
  localparam logic [2:0]         LIVES_INIT  = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  if (!gs_legal(GS)) begin : g_gs_check
    $error("drops_engine: GS must be a power of two in 4..16");
  end

  state_e                    state_q, state_d;
  logic [GS-2:0][GS-1:0]     grid_q, grid_d;
  logic [CW-1:0]             player_q, player_d;
  logic [CW-1:0]             scan_q, scan_d;
  logic [7:0]                tick_q, tick_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [2:0]                lives_q, lives_d;
  logic                      pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                      left_q, left_d, right_q, right_d, start_q, start_d;

  logic [15:0]               lfsr;
  logic                      unused_lfsr;
  logic                      left_rise, right_rise, start_rise;
  logic [GS-1:0]             player_mask, bottom, spawn_row;
  logic [GS-1:0][GS-1:0]     disp;
  logic                      catch_hit, miss_hit, step_due;

  drops_lfsr #(
    .W    (16),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .q_o   (lfsr)
  );

  assign unused_lfsr = ^lfsr[14:CW];

  assign left_rise  = left_i  & ~left_q;
  assign right_rise = right_i & ~right_q;
  assign start_rise = start_i & ~start_q;

  for (genvar gi = 0; gi < GS; gi++) begin : g_decode
    assign player_mask[gi] = (player_q == CW'(gi));
    assign row_o[gi]       = (state_q == ST_SCAN) && (scan_q == CW'(gi));
  end

  assign bottom    = grid_q[GS-2];
  assign catch_hit = |(bottom & player_mask);
  assign miss_hit  = |(bottom & ~player_mask);
  assign step_due  = (tick_q == TICK_LAST);
  assign spawn_row = lfsr[15] ? (GS'(1) << lfsr[CW-1:0]) : '0;

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    player_d = player_q;
    scan_d   = scan_q;
    tick_d   = tick_q;
    score_d  = score_q;
    lives_d  = lives_q;
    left_d   = left_i;
    right_d  = right_i;
    start_d  = start_i;
    // Presses accumulate until the next INPUT consumes them.
    pend_l_d = pend_l_q | left_rise;
    pend_r_d = pend_r_q | right_rise;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d  = ST_INPUT;
          grid_d   = '0;
          score_d  = '0;
          lives_d  = LIVES_INIT;
          tick_d   = '0;
          player_d = PLAYER_INIT;
        end
      end
      ST_INPUT: begin
        if (pend_l_q && !pend_r_q && (player_q != '0)) begin
          player_d = player_q - CW'(1);
        end else if (pend_r_q && !pend_l_q && (player_q != LAST_IDX)) begin
          player_d = player_q + CW'(1);
        end
        // An edge arriving in this very cycle belongs to the next frame.
        pend_l_d = left_rise;
        pend_r_d = right_rise;
        scan_d   = '0;
        state_d  = ST_STEP;
      end
      ST_STEP: begin
        if (step_due) begin
          tick_d = '0;
          if (catch_hit && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
          if (miss_hit && (lives_q != '0))         lives_d = lives_q - 3'd1;
          grid_d = {grid_q[GS-3:0], spawn_row};
        end else begin
          tick_d = tick_q + 8'd1;
        end
        state_d = (lives_d == '0) ? ST_OVER : ST_SCAN;
      end
      ST_SCAN: begin
        scan_d = scan_q + CW'(1);
        if (scan_q == LAST_IDX) state_d = ST_INPUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grid_q   <= '0;
      player_q <= PLAYER_INIT;
      scan_q   <= '0;
      tick_q   <= '0;
      score_q  <= '0;
      lives_q  <= LIVES_INIT;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      start_q  <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      player_q <= player_d;
      scan_q   <= scan_d;
      tick_q   <= tick_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      start_q  <= start_d;
    end
  end

  // Row GS-1 of the display is the paddle rather than a stored drop row.
  assign disp        = {player_mask, grid_q};
  assign col_o       = (state_q == ST_SCAN) ? disp[scan_q] : '0;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign game_over_o = (state_q == ST_OVER);
  assign frame_o     = (state_q == ST_INPUT);

endmodule

// File: tb/tb_drops_engine.sv
// Self-checking bench for drops_engine: a frame-level reference model is
// compared against every output on every cycle, plus targeted sequences.
module tb_drops_engine;

  localparam int          GS       = 8;
  localparam int          TICK_DIV = 2;
  localparam int          LIVES    = 3;
  localparam int          SCORE_W  = 8;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          FRAME    = GS + 2;
  localparam int          NPAD     = 11;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0;
  logic               left_i = 1'b0;
  logic               right_i = 1'b0;
  logic               start_i = 1'b0;
  logic [GS-1:0]      row_o, col_o;
  logic [SCORE_W-1:0] score_o;
  logic [2:0]         lives_o;
  logic               game_over_o, frame_o;

  always #5 clk = ~clk;

  drops_engine #(
    .GS(GS), .TICK_DIV(TICK_DIV), .LIVES(LIVES), .SCORE_W(SCORE_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .left_i(left_i), .right_i(right_i),
    .start_i(start_i), .row_o(row_o), .col_o(col_o), .score_o(score_o),
    .lives_o(lives_o), .game_over_o(game_over_o), .frame_o(frame_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          l;
    logic          r;
    logic [GS-1:0] exp_col;
  } pad_vec_t;
  pad_vec_t pad_tbl [NPAD];

  // Reference model: frame position is simply a counter 0..FRAME-1
  // (0 = input, 1 = step, 2.. = scan rows).
  logic [15:0]   m_lfsr;
  logic [GS-1:0] m_grid [GS-1];
  int            m_player, m_tick, m_score, m_lives, m_phase;
  bit            m_running, m_over, m_pend_l, m_pend_r;
  bit            m_prev_l, m_prev_r, m_prev_s;
  int            m_catches, m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lfsr = SEED;
    for (int r = 0; r < GS - 1; r++) m_grid[r] = '0;
    m_player  = GS / 2;
    m_tick    = 0;
    m_score   = 0;
    m_lives   = LIVES;
    m_phase   = 0;
    m_running = 0;
    m_over    = 0;
    m_pend_l  = 0;
    m_pend_r  = 0;
    m_prev_l  = 0;
    m_prev_r  = 0;
    m_prev_s  = 0;
  endfunction

  function automatic logic [GS-1:0] exp_row();
    logic [GS-1:0] v;
    v = '0;
    if (m_running && m_phase >= 2) v = GS'(1) << (m_phase - 2);
    return v;
  endfunction

  function automatic logic [GS-1:0] exp_col();
    logic [GS-1:0] v;
    v = '0;
    if (m_running && m_phase >= 2) begin
      if (m_phase - 2 == GS - 1) v = GS'(1) << m_player;
      else                       v = m_grid[m_phase - 2];
    end
    return v;
  endfunction

  function automatic void model_drop_step();
    logic [GS-1:0] bot;
    int            spawn_col;
    if (m_tick == TICK_DIV - 1) begin
      bot = m_grid[GS-2];
      if (bot[m_player]) begin
        if (m_score < (1 << SCORE_W) - 1) m_score++;
        m_catches++;
      end
      if ((bot & ~(GS'(1) << m_player)) != '0 && m_lives > 0) begin
        m_lives--;
        m_misses++;
      end
      for (int r = GS - 2; r > 0; r--) m_grid[r] = m_grid[r-1];
      spawn_col = int'(m_lfsr) % GS;
      m_grid[0] = m_lfsr[15] ? (GS'(1) << spawn_col) : '0;
      m_tick = 0;
    end else begin
      m_tick++;
    end
  endfunction

  function automatic void model_step(input bit l, input bit r, input bit s, input bit e);
    bit el, er, es;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!e) return;
    el = l && !m_prev_l;
    er = r && !m_prev_r;
    es = s && !m_prev_s;
    if (!m_running) begin
      m_pend_l |= el;
      m_pend_r |= er;
      if (es) begin
        for (int i = 0; i < GS - 1; i++) m_grid[i] = '0;
        m_score = 0; m_lives = LIVES; m_tick = 0; m_player = GS / 2;
        m_running = 1; m_over = 0; m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (m_pend_l && !m_pend_r)      m_player = (m_player > 0) ? m_player - 1 : 0;
      else if (m_pend_r && !m_pend_l) m_player = (m_player < GS - 1) ? m_player + 1 : GS - 1;
      m_pend_l = el;
      m_pend_r = er;
      m_phase  = 1;
    end else if (m_phase == 1) begin
      model_drop_step();
      if (m_lives == 0) begin
        m_running = 0;
        m_over    = 1;
      end else begin
        m_phase = 2;
      end
    end else begin
      m_pend_l |= el;
      m_pend_r |= er;
      m_phase = (m_phase == FRAME - 1) ? 0 : m_phase + 1;
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_prev_l = l;
    m_prev_r = r;
    m_prev_s = s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_row"},   row_o,       exp_row());
    chk({tag, "_col"},   col_o,       exp_col());
    chk({tag, "_score"}, score_o,     m_score);
    chk({tag, "_lives"}, lives_o,     m_lives);
    chk({tag, "_over"},  game_over_o, m_over);
    chk({tag, "_frame"}, frame_o,     m_running && m_phase == 0);
  endtask

  // Called at a falling edge: check the current state, drive the next inputs.
  task automatic cycle(input bit l, input bit r, input bit s, input bit e, input string tag);
    check_outputs(tag);
    left_i  = l;
    right_i = r;
    start_i = s;
    ena     = e;
    model_step(l, r, s, e);
    @(negedge clk);
  endtask

  task automatic run_to(input int p);
    int n;
    n = 0;
    while (!(m_running && m_phase == p) && n < 4 * FRAME) begin
      cycle(0, 0, 0, 1, "run");
      n++;
    end
    if (!(m_running && m_phase == p)) begin
      checks++;
      errors++;
      $display("FAIL run_to: frame position %0d not reached within %0d cycles", p, n);
    end
  endtask

  task automatic press(input bit l, input bit r);
    cycle(l, r, 0, 1, "press");
    cycle(l, r, 0, 1, "press");
    cycle(0, 0, 0, 1, "press");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k, n, target;
    int            frames;
    bit            pl, pr;
    logic [GS-1:0] er;

    // Paddle walk from the centre column (4): saturate left, both = no move.
    pad_tbl[0]  = '{1'b1, 1'b0, 8'h08};
    pad_tbl[1]  = '{1'b1, 1'b0, 8'h04};
    pad_tbl[2]  = '{1'b1, 1'b0, 8'h02};
    pad_tbl[3]  = '{1'b1, 1'b0, 8'h01};
    pad_tbl[4]  = '{1'b1, 1'b0, 8'h01};
    pad_tbl[5]  = '{1'b1, 1'b0, 8'h01};
    pad_tbl[6]  = '{1'b1, 1'b1, 8'h01};
    pad_tbl[7]  = '{1'b0, 1'b1, 8'h02};
    pad_tbl[8]  = '{1'b1, 1'b1, 8'h02};
    pad_tbl[9]  = '{1'b0, 1'b0, 8'h02};
    pad_tbl[10] = '{1'b0, 1'b1, 8'h04};

    m_catches = 0;
    m_misses  = 0;
    model_reset();
    @(negedge clk);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, "reset");
    chk("reset_row",   row_o,       0);
    chk("reset_col",   col_o,       0);
    chk("reset_score", score_o,     0);
    chk("reset_lives", lives_o,     LIVES);
    chk("reset_over",  game_over_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0, 1, "idle");
      chk("idle_frame", frame_o, 0);
    end

    // Start and the fixed frame rhythm.
    cycle(0, 0, 1, 1, "start");
    for (int i = 0; i < 2 * FRAME; i++) begin
      k = i % FRAME;
      er = (k >= 2) ? (GS'(1) << (k - 2)) : '0;
      chk("timing_frame", frame_o, (k == 0) ? 1 : 0);
      chk("timing_row", row_o, er);
      if (k == FRAME - 1) chk("timing_paddle", col_o, 8'h10);
      cycle(0, 0, 0, 1, "timing");
    end
    $display("frame timing: period %0d cycles checked", FRAME);

    // Table-driven paddle moves, one press per frame.
    for (int i = 0; i < NPAD; i++) begin
      run_to(3);
      press(pad_tbl[i].l, pad_tbl[i].r);
      if (i > 0) begin
        run_to(GS + 1);
        chk("paddle_tbl", col_o, pad_tbl[i-1].exp_col);
        $display("pad %0d: l=%0d r=%0d col=%02h", i - 1, pad_tbl[i-1].l, pad_tbl[i-1].r, col_o);
      end
    end
    run_to(0);
    run_to(GS + 1);
    chk("paddle_tbl", col_o, pad_tbl[NPAD-1].exp_col);
    $display("pad %0d: l=%0d r=%0d col=%02h", NPAD - 1, pad_tbl[NPAD-1].l, pad_tbl[NPAD-1].r, col_o);

    // Random play, mostly chasing the lowest drop, until the game ends.
    frames = 0;
    while (!m_over && frames < 300) begin
      n = 0;
      while (m_running && m_phase != 3 && n < 3 * FRAME) begin
        cycle(0, 0, 0, 1, "play");
        n++;
      end
      if (!m_running) break;
      target = -1;
      for (int r = 0; r < GS - 1; r++)
        for (int c = 0; c < GS; c++)
          if (m_grid[r][c]) target = c;
      if (target >= 0 && $urandom_range(0, 3) != 0) begin
        pl = (target < m_player);
        pr = (target > m_player);
      end else begin
        pl = $urandom_range(0, 1) == 1;
        pr = $urandom_range(0, 1) == 1;
      end
      press(pl, pr);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, "stall");
      end
      $display("frame %0d: l=%0d r=%0d player=%0d score=%0d lives=%0d",
               frames, pl, pr, m_player, score_o, lives_o);
      frames++;
    end

    if (m_over) begin
      $display("game over after %0d frames: catches=%0d misses=%0d", frames, m_catches, m_misses);
    end else begin
      checks++;
      errors++;
      $display("FAIL play: game over not reached in %0d frames", frames);
    end

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, "over");
    chk("over_row",   row_o,       0);
    chk("over_col",   col_o,       0);
    chk("over_flag",  game_over_o, 1);
    chk("over_lives", lives_o,     0);

    // Restart from OVER.
    cycle(0, 0, 1, 1, "restart");
    chk("restart_over",  game_over_o, 0);
    chk("restart_score", score_o,     0);
    chk("restart_lives", lives_o,     LIVES);
    chk("restart_frame", frame_o,     1);
    cycle(0, 0, 0, 1, "restart");

    // Enable low mid-scan: everything holds.
    run_to(5);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, "freeze");
      chk("freeze_row", row_o, 8'h08);
    end
    for (int i = 0; i < 3 * FRAME; i++) cycle(0, 0, 0, 1, "resume");

    // Asynchronous reset in the middle of a scan.
    run_to(6);
    chk("pre_arst_row", row_o, 8'h10);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_row",   row_o,       0);
    chk("arst_col",   col_o,       0);
    chk("arst_score", score_o,     0);
    chk("arst_lives", lives_o,     LIVES);
    chk("arst_over",  game_over_o, 0);
    chk("arst_frame", frame_o,     0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, "arst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, "post_arst");
    cycle(0, 0, 1, 1, "start2");
    for (int i = 0; i < 3 * FRAME; i++) cycle(0, 0, 0, 1, "post_start");
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
